// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one 4-bit carry-select slice,
// one nibble per cycle LSB first, behind valid/ready handshakes on both sides.

module csa (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] chain0;
    logic [4:0] chain1;
    logic [3:0] sum0;
    logic [3:0] sum1;

    assign chain0[0] = 1'b0;
    assign chain1[0] = 1'b1;

    // Both carry hypotheses ripple in parallel; the real carry-in only drives the final mux.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum0[gi]       = a[gi] ^ b[gi] ^ chain0[gi];
            assign chain0[gi + 1] = (a[gi] & b[gi]) | (chain0[gi] & (a[gi] ^ b[gi]));
            assign sum1[gi]       = a[gi] ^ b[gi] ^ chain1[gi];
            assign chain1[gi + 1] = (a[gi] & b[gi]) | (chain1[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign sum   = c_in ? sum1 : sum0;
    assign c_out = c_in ? chain1[4] : chain0[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0] res_reg,    res_next;
    logic             carry_reg,  carry_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic             a_msb_reg,  a_msb_next;
    logic             b_msb_reg,  b_msb_next;

    logic [3:0]       slice_sum;
    logic             slice_c_out;
    logic [WIDTH+3:0] res_wide;

    csa u_csa (
        .a     (a_sh_reg[3:0]),
        .b     (b_sh_reg[3:0]),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_c_out)
    );

    // New nibble enters at the top so after N shifts nibble 0 lands at the bottom.
    assign res_wide = {slice_sum, res_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            res_reg   <= res_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        res_next   = res_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        a_msb_next = a_msb_reg;
        b_msb_next = b_msb_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = c_in;
                    cnt_next   = '0;
                    a_msb_next = a[WIDTH-1];
                    b_msb_next = b[WIDTH-1];
                    state_next = RUN;
                end
            end
            RUN: begin
                res_next   = res_wide[WIDTH+3:4];
                a_sh_next  = a_sh_reg >> 4;
                b_sh_next  = b_sh_reg >> 4;
                carry_next = slice_c_out;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = res_reg;
    assign c_out     = carry_reg;
    assign overflow  = (state_reg == DONE) && (a_msb_reg == b_msb_reg)
                       && (res_reg[WIDTH-1] != a_msb_reg);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench: stimulus pushes hand-computed results into a scoreboard,
// an independent monitor pops and compares on every output handshake.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              c_out;
    logic              overflow;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    logic prev_ov  = 1'b0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Output monitor: latency is measured from the accepting edge to the first out_valid cycle.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got sum 0x%0h expected no result", sum);
            end else begin
                mon_e = sb.pop_front();
                $display("result sum=0x%04h c_out=%0b overflow=%0b", sum, c_out, overflow);
                chk("sum", 32'(sum), 32'(mon_e.sum));
                chk("c_out", 32'(c_out), 32'(mon_e.cout));
                chk("overflow", 32'(overflow), 32'(mon_e.ovf));
                chk("latency", 32'(rise_cyc - mon_e.acc_cyc), 32'(N));
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input bit keep, input bit push, output int acc);
        int   waited = 0;
        bit   got    = 0;
        exp_t tmp;
        a        = av;
        b        = bv;
        c_in     = cv;
        in_valid = 1'b1;
        acc      = 0;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                acc = cyc + 1;
                $display("accept a=0x%04h b=0x%04h c_in=%0b at edge %0d", av, bv, cv, acc);
                if (push) begin
                    tmp.sum     = es;
                    tmp.cout    = ec;
                    tmp.ovf     = eo;
                    tmp.acc_cyc = acc;
                    sb.push_back(tmp);
                end
            end
            waited++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    initial begin
        int acc0;
        int acc1;
        int acc2;
        int waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_c_out", 32'(c_out), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1, acc0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1, acc0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1, acc0);
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0, 1, acc0);

        // Reset coinciding with a handshake must leave the block idle.
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 50);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0101;
        b        = 16'h0202;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wins_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wins_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: results must hold while DONE is stalled and inputs churn.
        out_ready = 1'b0;
        do_op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1, acc0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        for (int i = 0; i < 3; i++) begin
            chk("bp_sum", 32'(sum), 32'h8000);
            chk("bp_c_out", 32'(c_out), 32'd0);
            chk("bp_overflow", 32'(overflow), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = ~in_valid;
            c_in     = ~c_in;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1, acc0);

        // Reset during the second RUN cycle discards the operation.
        do_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 0, acc0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_c_out", 32'(c_out), 32'd0);
        @(posedge clk);
        #1;
        do_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1, acc0);

        // Back-to-back with in_valid and out_ready held high.
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1, acc1);
        do_op(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0, 0, 1, acc2);
        chk("b2b_spacing", 32'(acc2 - acc1), 32'(N + 2));

        waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Area-reduced WIDTH-bit adder that reuses one 4-bit `csa` carry-select slice over multiple cycles. The block feeds the slice one nibble per cycle, least-significant first, and carries the slice's carry-out into the next nibble through a register. It also collects the slice's sum nibbles into the full-width result. It has valid/ready handshakes on both sides so it can sit between operand-producing and result-consuming stages of the datapath.

## Interface

Parameters:
- `WIDTH`, default 16: operand and result width in bits. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands `a`, `b`, `c_in` are valid.
- `in_ready`, output, 1: block can accept an operation.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `c_in`, input, 1: carry into bit 0.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `sum`, output, WIDTH: a + b + c_in, modulo 2^WIDTH.
- `c_out`, output, 1: carry out of bit WIDTH-1.
- `overflow`, output, 1: two's-complement signed overflow.

## Operation

- One `csa` instance. Its inputs are the low nibble of the A shift register, the low nibble of the B shift register, and the carry register. No other adder logic is permitted in the datapath.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `a`, `b` into the shift registers.
  - carry register ← `c_in`; nibble counter ← 0.
  - Store `a[WIDTH-1]`, `b[WIDTH-1]`.
  - Go to RUN.
- RUN, each cycle:
  - The result register shifts right by 4, and the csa Sum enters at bits [WIDTH-1:WIDTH-4].
  - The A and B shift registers shift right by 4.
  - carry register ← csa C_out; counter increments.
  - When counter = N-1 in the current cycle, go to DONE.
- DONE:
  - `out_valid`=1; `sum` = result register; `c_out` = carry register.
  - `overflow` = (stored a_msb == stored b_msb) && (sum[WIDTH-1] != stored a_msb).
  - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE.
- `in_valid` in RUN or DONE is ignored and has no effect on state.
- `sum`, `c_out` and `overflow` are held stable throughout DONE regardless of input changes.
- Counter width: clog2(N)+1 bits. It does not wrap within an operation.

## Timing

- Reset: state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `c_out`=0, `overflow`=0, and all internal registers = 0.
- Accept handshake at edge E0. Nibble i is computed between E_i and E_{i+1}, for i = 0..N-1.
- `out_valid` rises after edge E_N, so latency is N cycles from accept (4 for WIDTH=16).
- DONE with `out_ready`=1 lasts 1 cycle, then IDLE lasts at least 1 cycle. Maximum throughput is one operation per N+2 cycles.
- There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- `rst` in any state aborts the operation at the next edge. All outputs return to reset values and the partial result is discarded.
- `rst` and a handshake in the same cycle: reset wins and the operation is not accepted.

## Test plan

- WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> `out_valid` exactly 4 cycles after accept; `sum`=0x5555, `c_out`=0, `overflow`=0.
- a=0xFFFF, b=0x0001, c_in=0 -> `sum`=0x0000, `c_out`=1, `overflow`=0. The carry must ripple through all 4 nibble cycles.
- a=0x7FFF, b=0x0001, c_in=0 -> `sum`=0x8000, `c_out`=0, `overflow`=1. Also a=0x0000, b=0x0000, c_in=1 -> `sum`=0x0001, `c_out`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE, toggling `a`, `b`, `in_valid` meanwhile -> `sum`, `c_out`, `overflow` stable, `in_ready`=0, no new accept. Release -> IDLE next cycle, then the next accept.
- Reset mid-operation: assert `rst` in the second RUN cycle of a=0x1111, b=0x2222 -> next cycle `out_valid`=0, `in_ready`=1, `sum`=0. A subsequent a=0x00FF, b=0x0F01, c_in=0 gives `sum`=0x1000, `c_out`=0.
- Back-to-back: 2 operations with `in_valid` and `out_ready` held at 1 -> second accept exactly N+2 cycles after the first, and both results correct.
